ddr_axi_addr_merger: RTL
========================

// Module: ddr_axi_addr_merger
// PURPOSE
//  Upstream stage of the simulation DDR model. Merges the separate AXI AW and AR address channels into
//  the DDR single address channel (aid_0..atype_0, atype 1=write, 0=read). A one-entry output register
//  holds the merged command. Per-direction outstanding counters throttle issue.
// PARAMETERS
//  MAX_OUTSTANDING  4   max writes (or reads) accepted and not yet responded to, per direction; 1..15
//  AW               32  address width; aaddr_0 passed through unmodified
// PORTS
//  mem_clk          in   1   clock
//  resetn           in   1   async active-low reset
//  s_aw{id,addr,len,size,burst,lock}  in  8/AW/8/3/2/2  AXI write address fields
//  s_awvalid        in   1   write address valid
//  s_awready        out  1   write address accepted (combinational)
//  s_ar{id,addr,len,size,burst,lock}  in  8/AW/8/3/2/2  AXI read address fields
//  s_arvalid        in   1   read address valid
//  s_arready        out  1   read address accepted (combinational)
//  aid_0,aaddr_0,alen_0,asize_0,aburst_0,alock_0  out  8/AW/8/3/2/2  merged command (registered)
//  atype_0          out  1   1=write, 0=read
//  avalid_0         out  1   command valid
//  aready_0         in   1   DDR accepts command
//  bvalid_0,bready_0          in  1   write response monitor
//  rvalid_0,rready_0,rlast_0  in  1   read data monitor
//  wr_outstanding   out  4   writes in flight
//  rd_outstanding   out  4   reads in flight
//  err_underflow    out  1   sticky: response seen with counter at 0
// BEHAVIOUR
//  - Reset: avalid_0=0, all command fields=0, atype_0=0, counters=0, err_underflow=0, rr pointer=write-first.
//  - Slot FSM: EMPTY/FULL. slot_free = EMPTY | (avalid_0 & aready_0). Throughput is 1 cmd/cycle.
//  - Eligibility: wr_ok = s_awvalid & (wr_outstanding<MAX_OUTSTANDING); rd_ok likewise for reads.
//  - Grant only when slot_free. Both eligible: round-robin, and the pointer toggles after each grant.
//    If one is eligible, it is granted and the pointer points away from it.
//  - s_awready = slot_free & grant_wr; s_arready = slot_free & grant_rd. Never both in one cycle.
//  - On grant, the command loads next edge and avalid_0=1 (1-cycle latency valid->avalid_0).
//    No grant with the slot freed: avalid_0=0.
//  - Fields are stable while avalid_0 & ~aready_0 (AXI hold rule).
//  - wr_outstanding: +1 on AW handshake, -1 on bvalid_0&bready_0. Both in the same cycle: unchanged.
//  - rd_outstanding: +1 on AR handshake, -1 on rvalid_0&rready_0&rlast_0. Both in the same cycle: unchanged.
//  - Counter at MAX: that direction is ineligible, and the other is still served.
//    Decrement at 0: the counter holds 0 and err_underflow sets, cleared only by reset.
//  - Reset mid-burst: the command is dropped and counters clear. Upstream must also be reset.
// CONFIGURATION
//  WRITE_PRIORITY_EN defined: fixed priority and the rr pointer is removed.
//    Writes win whenever wr_ok, and reads are granted only when ~wr_ok.
//  Undefined: round-robin as above.
// STRUCTURE
//  - Package ddr_axi_pkg holds:
//    - ATYPE_WR=1'b1 and ATYPE_RD=1'b0
//    - ID_W=8, LEN_W=8, SIZE_W=3, BURST_W=2, LOCK_W=2
//    - packed struct ddr_acmd_t {id,addr,len,size,burst,lock,atype}
//  - One sub-module, ddr_rr_arb2: a 2-requester round-robin arbiter with an enable and grant outputs.
//    The top instantiates it unless WRITE_PRIORITY_EN is defined.
// TESTING
//  1 Single write, aready_0 tied 1: s_awaddr=0x100, awlen=3, awvalid 1 cycle
//    -> awready same cycle; next cycle avalid_0=1, atype_0=1, aaddr_0=0x100, alen_0=3.
//    wr_outstanding=1 until bvalid&bready, then 0.
//  2 AW and AR valid every cycle, aready_0=1, responses returned
//    -> grants alternate W,R,W,R with no idle cycles after the first.
//  3 aready_0=0 for 5 cycles with avalid_0=1
//    -> fields hold, and s_awready/s_arready stay 0 throughout.
//  4 MAX_OUTSTANDING=2, 3 writes issued, no bvalid
//    -> third awready withheld and AR still granted. One bvalid pulse -> third write accepted.
//  5 bvalid&bready with wr_outstanding=0 -> counter stays 0 and err_underflow=1 until reset.
//  6 WRITE_PRIORITY_EN build, AW and AR continuously valid
//    -> only writes granted until wr_outstanding hits MAX, then reads.
//  7 resetn asserted with avalid_0=1 -> avalid_0=0 and counters=0 immediately (async).

Source files
------------

// File: rtl/ddr_axi_pkg.sv
// Shared types and constants for the DDR model AXI address merger.
package ddr_axi_pkg;

  localparam logic ATYPE_WR = 1'b1;
  localparam logic ATYPE_RD = 1'b0;

  localparam int unsigned ID_W       = 8;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned BURST_W    = 2;
  localparam int unsigned LOCK_W     = 2;
  localparam int unsigned ADDR_MAX_W = 64;

  // addr is sized for the widest supported AW; the top truncates on output
  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [ADDR_MAX_W-1:0] addr;
    logic [LEN_W-1:0]      len;
    logic [SIZE_W-1:0]     size;
    logic [BURST_W-1:0]    burst;
    logic [LOCK_W-1:0]     lock;
    logic                  atype;
  } ddr_acmd_t;

  function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
    if (inc && !dec) return cnt + 4'd1;
    if (dec && !inc && cnt != '0) return cnt - 4'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/ddr_rr_arb2.sv
// Two-requester round-robin arbiter (write/read); the pointer always moves away
// from the side just granted, so it toggles when both were requesting.
module ddr_rr_arb2 (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic ptr_wr;

  always_comb begin
    gnt_wr = en & req_wr & (~req_rd | ptr_wr);
    gnt_rd = en & req_rd & (~req_wr | ~ptr_wr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               ptr_wr <= 1'b1;
    else if (gnt_wr | gnt_rd)  ptr_wr <= gnt_rd;
  end

endmodule

// File: rtl/ddr_axi_addr_merger.sv
// Merges AXI AW/AR into the DDR model's single registered address channel.
// Define WRITE_PRIORITY_EN for fixed write priority instead of round-robin.
module ddr_axi_addr_merger
  import ddr_axi_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned AW              = 32
) (
  input  logic               mem_clk,
  input  logic               resetn,
  input  logic [ID_W-1:0]    s_awid,
  input  logic [AW-1:0]      s_awaddr,
  input  logic [LEN_W-1:0]   s_awlen,
  input  logic [SIZE_W-1:0]  s_awsize,
  input  logic [BURST_W-1:0] s_awburst,
  input  logic [LOCK_W-1:0]  s_awlock,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [ID_W-1:0]    s_arid,
  input  logic [AW-1:0]      s_araddr,
  input  logic [LEN_W-1:0]   s_arlen,
  input  logic [SIZE_W-1:0]  s_arsize,
  input  logic [BURST_W-1:0] s_arburst,
  input  logic [LOCK_W-1:0]  s_arlock,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [ID_W-1:0]    aid_0,
  output logic [AW-1:0]      aaddr_0,
  output logic [LEN_W-1:0]   alen_0,
  output logic [SIZE_W-1:0]  asize_0,
  output logic [BURST_W-1:0] aburst_0,
  output logic [LOCK_W-1:0]  alock_0,
  output logic               atype_0,
  output logic               avalid_0,
  input  logic               aready_0,
  input  logic               bvalid_0,
  input  logic               bready_0,
  input  logic               rvalid_0,
  input  logic               rready_0,
  input  logic               rlast_0,
  output logic [3:0]         wr_outstanding,
  output logic [3:0]         rd_outstanding,
  output logic               err_underflow
);

  typedef enum logic {EMPTY, FULL} slot_state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  slot_state_t state_q, state_d;
  ddr_acmd_t   cmd_q, cmd_d;
  logic        slot_free, wr_ok, rd_ok, grant_wr, grant_rd;
  logic        wr_inc, wr_dec, rd_inc, rd_dec;

  assign slot_free = (state_q == EMPTY) | (avalid_0 & aready_0);
  assign wr_ok     = s_awvalid & (wr_outstanding < MAX_CNT);
  assign rd_ok     = s_arvalid & (rd_outstanding < MAX_CNT);

`ifdef WRITE_PRIORITY_EN
  assign grant_wr = slot_free & wr_ok;
  assign grant_rd = slot_free & rd_ok & ~wr_ok;
`else
  ddr_rr_arb2 u_arb (
    .clk    (mem_clk),
    .resetn (resetn),
    .en     (slot_free),
    .req_wr (wr_ok),
    .req_rd (rd_ok),
    .gnt_wr (grant_wr),
    .gnt_rd (grant_rd)
  );
`endif

  assign s_awready = slot_free & grant_wr;
  assign s_arready = slot_free & grant_rd;

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (s_awready | s_arready) state_d = FULL;
      FULL:  if (slot_free)             state_d = (s_awready | s_arready) ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    avalid_0 = (state_q == FULL);
  end

  always_comb begin
    cmd_d = '0;
    if (grant_wr) begin
      cmd_d.id    = s_awid;
      cmd_d.addr  = ADDR_MAX_W'(s_awaddr);
      cmd_d.len   = s_awlen;
      cmd_d.size  = s_awsize;
      cmd_d.burst = s_awburst;
      cmd_d.lock  = s_awlock;
      cmd_d.atype = ATYPE_WR;
    end else begin
      cmd_d.id    = s_arid;
      cmd_d.addr  = ADDR_MAX_W'(s_araddr);
      cmd_d.len   = s_arlen;
      cmd_d.size  = s_arsize;
      cmd_d.burst = s_arburst;
      cmd_d.lock  = s_arlock;
      cmd_d.atype = ATYPE_RD;
    end
  end

  // Loading only on a handshake keeps fields stable while stalled
  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn)                     cmd_q <= '0;
    else if (s_awready | s_arready)  cmd_q <= cmd_d;
  end

  assign aid_0    = cmd_q.id;
  assign aaddr_0  = AW'(cmd_q.addr);
  assign alen_0   = cmd_q.len;
  assign asize_0  = cmd_q.size;
  assign aburst_0 = cmd_q.burst;
  assign alock_0  = cmd_q.lock;
  assign atype_0  = cmd_q.atype;

  assign wr_inc = s_awvalid & s_awready;
  assign wr_dec = bvalid_0 & bready_0;
  assign rd_inc = s_arvalid & s_arready;
  assign rd_dec = rvalid_0 & rready_0 & rlast_0;

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      wr_outstanding <= '0;
      rd_outstanding <= '0;
      err_underflow  <= 1'b0;
    end else begin
      wr_outstanding <= cnt_next(wr_outstanding, wr_inc, wr_dec);
      rd_outstanding <= cnt_next(rd_outstanding, rd_inc, rd_dec);
      if ((wr_dec & ~wr_inc & (wr_outstanding == '0)) |
          (rd_dec & ~rd_inc & (rd_outstanding == '0)))
        err_underflow <= 1'b1;
    end
  end

endmodule
